// File: rtl/xnor_cmp_pkg.sv
// Shared types and limits for the serial XNOR word comparator.
package xnor_cmp_pkg;

    localparam int unsigned FRAME_LEN_MAX = 1024;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } cmp_state_t;

endpackage : xnor_cmp_pkg

// File: rtl/bit_match_cell.sv
// Per-bit XNOR match plus the running whole-frame AND accumulator.
module bit_match_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic clr,
    input  logic en,
    output logic match_c,
    output logic acc_c,
    output logic acc_q
);

    logic acc_d;

    always_comb begin
        match_c = ~(a ^ b);
        acc_d   = acc_q;
        if (clr) begin
            acc_d = 1'b1;
        end else if (en) begin
            acc_d = acc_q & match_c;
        end
        acc_c = acc_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= 1'b1;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule : bit_match_cell

// File: rtl/serial_xnor_comparator.sv
// Bit-serial frame comparator: FSM, bit counter and optional mismatch counter.
// Optional Hamming-distance output enabled by SERIAL_XNOR_COMPARATOR_MISMATCH_CNT_EN.
module serial_xnor_comparator
    import xnor_cmp_pkg::*;
#(
    parameter  int unsigned FRAME_LEN = 8,
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             a,
    input  logic             b,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic [CNT_W-1:0] mismatch_cnt
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

    cmp_state_t       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             equal_q, equal_d;
    logic             accept_c;
    logic             take_bit_c;
    logic             last_bit_c;
    logic             match_c;
    logic             acc_c;
    logic             acc_q;

    assign accept_c   = (state_q == S_IDLE) && start;
    assign take_bit_c = (state_q == S_RUN) && bit_valid;
    assign last_bit_c = take_bit_c && (bit_cnt_q == LAST_BIT);

    bit_match_cell u_match (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .clr     (accept_c),
        .en      (take_bit_c),
        .match_c (match_c),
        .acc_c   (acc_c),
        .acc_q   (acc_q)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_bit_c) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        busy_d    = (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
        bit_cnt_d = bit_cnt_q;
        equal_d   = equal_q;
        if (accept_c) begin
            bit_cnt_d = '0;
            equal_d   = 1'b0;
        end else if (take_bit_c) begin
            // Counter parks at zero after the last bit instead of running past it
            bit_cnt_d = last_bit_c ? '0 : bit_cnt_q + CNT_W'(1);
            if (last_bit_c) begin
                equal_d = acc_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            equal_q   <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            equal_q   <= equal_d;
        end
    end

`ifdef SERIAL_XNOR_COMPARATOR_MISMATCH_CNT_EN
    logic [CNT_W-1:0] mm_cnt_q, mm_cnt_d;
    logic [CNT_W-1:0] mismatch_q, mismatch_d;
    logic             diff_c;

    // Running Hamming distance; published only when the frame completes
    always_comb begin
        diff_c     = ~match_c;
        mm_cnt_d   = mm_cnt_q;
        mismatch_d = mismatch_q;
        if (accept_c) begin
            mm_cnt_d = '0;
        end else if (take_bit_c) begin
            mm_cnt_d = mm_cnt_q + CNT_W'(diff_c);
            if (last_bit_c) begin
                mismatch_d = mm_cnt_q + CNT_W'(diff_c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mm_cnt_q   <= '0;
            mismatch_q <= '0;
        end else begin
            mm_cnt_q   <= mm_cnt_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch_cnt = mismatch_q;
`else
    assign mismatch_cnt = '0;
`endif

    assign busy  = busy_q;
    assign done  = done_q;
    assign equal = equal_q;

endmodule : serial_xnor_comparator

// File: tb/tb_serial_xnor_comparator.sv
// Scoreboard bench for serial_xnor_comparator (FRAME_LEN=8), either macro setting.
module tb_serial_xnor_comparator;

    localparam int unsigned FRAME_LEN = 8;
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);

    typedef struct packed {
        logic        eq;
        logic [31:0] mm;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             bit_valid;
    logic             a;
    logic             b;
    logic             busy;
    logic             done;
    logic             equal;
    logic [CNT_W-1:0] mismatch_cnt;

    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    serial_xnor_comparator #(.FRAME_LEN(FRAME_LEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .bit_valid    (bit_valid),
        .a            (a),
        .b            (b),
        .busy         (busy),
        .done         (done),
        .equal        (equal),
        .mismatch_cnt (mismatch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic exp_t model(input logic [7:0] aw, input logic [7:0] bw);
        exp_t e;
        e.eq = (aw == bw);
`ifdef SERIAL_XNOR_COMPARATOR_MISMATCH_CNT_EN
        e.mm = 32'($countones(aw ^ bw));
`else
        e.mm = 32'd0;
`endif
        return e;
    endfunction

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    // Drives 8 bits LSB first; stall_mask[i] inserts an idle cycle before bit i.
    task automatic send_frame(input logic [7:0] aw, input logic [7:0] bw,
                              input logic [7:0] stall_mask, input logic hold_start);
        exp_q.push_back(model(aw, bw));
        for (int i = 0; i < 8; i++) begin
            if (stall_mask[i]) begin
                bit_valid = 1'b0;
                a = ~aw[i];
                b = bw[i];
                tick();
                check("busy_in_stall", 32'(busy), 32'd1);
            end
            start     = hold_start;
            bit_valid = 1'b1;
            a         = aw[i];
            b         = bw[i];
            tick();
            check("done_timing", 32'(done), (i == 7) ? 32'd1 : 32'd0);
        end
        bit_valid = 1'b0;
        start     = 1'b0;
    endtask

    // Scoreboard: every done pulse must match the oldest pending frame.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("equal", 32'(equal), 32'(e.eq));
                check("mismatch_cnt", 32'(mismatch_cnt), e.mm);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [CNT_W-1:0] held_mm;
        rst_n = 1'b0; start = 1'b0; bit_valid = 1'b0; a = 1'b0; b = 1'b0;
        tick(); tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_equal", 32'(equal), 32'd0);
        check("rst_mm", 32'(mismatch_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: equal words
        do_start();
        send_frame(8'hA5, 8'hA5, 8'h00, 1'b0);
        tick();
        check("busy_idle_1", 32'(busy), 32'd0);

        // 2: single-bit difference
        do_start();
        send_frame(8'hA5, 8'hA4, 8'h00, 1'b0);
        tick();

        // 3: all bits differ, stalls before bits 3 and 6
        do_start();
        send_frame(8'hFF, 8'h00, 8'h48, 1'b0);
        tick();

        // 4: reset after 4 bits aborts the frame
        do_start();
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1; a = 1'b1; b = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_equal", 32'(equal), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();
        check("abort_no_done", 32'(done), 32'd0);
        do_start();
        send_frame(8'h3C, 8'h3C, 8'h00, 1'b0);
        tick();

        // 5: start held through RUN and DONE, bit_valid pulsed in IDLE
        do_start();
        send_frame(8'h5A, 8'h5A, 8'h00, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_done", 32'(busy), 32'd0);
        bit_valid = 1'b1; a = 1'b1; b = 1'b0;
        tick();
        bit_valid = 1'b0;
        check("idle_bit_ignored", 32'(busy), 32'd0);
        do_start();
        send_frame(8'h00, 8'h00, 8'h00, 1'b0);

        // 6: back-to-back frames, start in first legal cycle
        tick();
        do_start();
        send_frame(8'hC3, 8'hC3, 8'h00, 1'b0);
        tick();
        check("equal_held", 32'(equal), 32'd1);
        held_mm = mismatch_cnt;
        do_start();
        check("equal_cleared", 32'(equal), 32'd0);
        check("mm_held_on_start", 32'(mismatch_cnt), 32'(held_mm));
        send_frame(8'hC3, 8'h81, 8'h00, 1'b0);
        tick(); tick();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_serial_xnor_comparator
